// File: rtl/flux_tag_arbiter.sv
// flux_tag_arbiter: merges FLUX valid/ready producer streams into one tagged
// FIFO write port. Each stream has a single-word holding register. Streams that
// are held and whose FIFO queue is not full are arbitrated, and the stream index
// is packed into the top TAG_WIDTH bits of fifo_data.
// Optional feature: define FLUX_ARB_FIXED_PRIO_EN to select fixed priority,
// where the highest eligible index wins. Otherwise round-robin is used.
module flux_tag_arbiter #(
    parameter  int WIDTH     = 8,
    parameter  int FLUX      = 2,
    localparam int TAG_WIDTH = $clog2(FLUX),
    localparam int PAYLOAD   = WIDTH - TAG_WIDTH
) (
    input  logic                    ck,
    input  logic                    rst,
    input  logic [FLUX-1:0]         in_valid,
    input  logic [FLUX*PAYLOAD-1:0] in_data,
    output logic [FLUX-1:0]         in_ready,
    input  logic [FLUX-1:0]         fifo_full,
    output logic                    fifo_wr,
    output logic [WIDTH-1:0]        fifo_data
);

    logic [FLUX-1:0]      hold_v;
    logic [PAYLOAD-1:0]   hold_d [FLUX];
    logic [TAG_WIDTH-1:0] last_grant;

    logic [FLUX-1:0]      elig;
    logic                 grant_v;
    logic [TAG_WIDTH-1:0] grant;
    logic [PAYLOAD-1:0]   grant_d;

    // Eligibility uses the current fifo_full; the FIFO commits on the same edge.
    always_comb begin
        elig = hold_v & ~fifo_full;
    end

`ifdef FLUX_ARB_FIXED_PRIO_EN
    // Fixed priority: later (higher) eligible indices overwrite earlier ones.
    always_comb begin
        grant_v = 1'b0;
        grant   = '0;
        grant_d = '0;
        for (int unsigned i = 0; i < FLUX; i++) begin
            if (elig[i]) begin
                grant_v = 1'b1;
                grant   = TAG_WIDTH'(i);
                grant_d = hold_d[i];
            end
        end
    end
`else
    // Round-robin: search from last_grant+1, wrapping modulo FLUX; first eligible wins.
    always_comb begin
        int unsigned idx;
        grant_v = 1'b0;
        grant   = '0;
        grant_d = '0;
        idx     = 0;
        for (int unsigned k = 1; k <= FLUX; k++) begin
            idx = (int'(last_grant) + k) % FLUX;
            if (!grant_v && elig[idx]) begin
                grant_v = 1'b1;
                grant   = TAG_WIDTH'(idx);
                grant_d = hold_d[idx];
            end
        end
    end
`endif

    // A stream can accept when empty or when its held word is drained this cycle.
    always_comb begin
        for (int unsigned i = 0; i < FLUX; i++) begin
            in_ready[i] = ~hold_v[i] | (grant_v && (grant == TAG_WIDTH'(i)));
        end
    end

    // Tagged write port; data forced to zero when there is no write.
    always_comb begin
        fifo_wr   = grant_v;
        fifo_data = grant_v ? {grant, grant_d} : '0;
    end

    // Holding registers: accept takes precedence over drain, so a same-cycle
    // refill replaces the granted word and keeps hold_v set.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            hold_v <= '0;
            for (int unsigned i = 0; i < FLUX; i++) begin
                hold_d[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < FLUX; i++) begin
                if (in_valid[i] && in_ready[i]) begin
                    hold_v[i] <= 1'b1;
                    hold_d[i] <= in_data[i*PAYLOAD +: PAYLOAD];
                end else if (grant_v && (grant == TAG_WIDTH'(i))) begin
                    hold_v[i] <= 1'b0;
                end
            end
        end
    end

    // Round-robin pointer; holds when nothing is granted.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            last_grant <= TAG_WIDTH'(FLUX - 1);
        end else if (grant_v) begin
            last_grant <= grant;
        end
    end

endmodule

// File: tb/tb_flux_tag_arbiter.sv
// Directed testbench for flux_tag_arbiter with WIDTH=8, FLUX=2 (1-bit tag,
// 7-bit payload). Expected values are hand-computed; the fixed-priority
// build (FLUX_ARB_FIXED_PRIO_EN) swaps in its own expectations where they differ.
module tb_flux_tag_arbiter;

    localparam int WIDTH = 8;
    localparam int FLUX  = 2;
    localparam int PL    = 7;

    logic              ck;
    logic              rst;
    logic [FLUX-1:0]   in_valid;
    logic [FLUX*PL-1:0] in_data;
    logic [FLUX-1:0]   in_ready;
    logic [FLUX-1:0]   fifo_full;
    logic              fifo_wr;
    logic [WIDTH-1:0]  fifo_data;

    int n_pass;
    int n_total;

    flux_tag_arbiter #(.WIDTH(WIDTH), .FLUX(FLUX)) dut (
        .ck        (ck),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .fifo_full (fifo_full),
        .fifo_wr   (fifo_wr),
        .fifo_data (fifo_data)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Check all three outputs of the current cycle.
    task automatic chk_out(input string tag, input logic [1:0] rdy, input logic wr,
                           input logic [7:0] data);
        chk({tag, ".in_ready"}, 16'(in_ready), 16'(rdy));
        chk({tag, ".fifo_wr"}, 16'(fifo_wr), 16'(wr));
        chk({tag, ".fifo_data"}, 16'(fifo_data), 16'(data));
    endtask

    task automatic set_in(input logic [1:0] v, input logic [6:0] d1, input logic [6:0] d0);
        in_valid = v;
        in_data  = {d1, d0};
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge ck);
        #1;
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b1;
        fifo_full = 2'b00;
        set_in(2'b00, 7'h00, 7'h00);
        #3;
        chk_out("reset", 2'b11, 1'b0, 8'h00);
        step();
        step();
        rst = 1'b0;

        // Single stream: 7'h15 on stream1 appears the next cycle as 8'h95.
        set_in(2'b10, 7'h15, 7'h00);
        #2 chk_out("s1_load", 2'b11, 1'b0, 8'h00);
        step();
        set_in(2'b00, 7'h00, 7'h00);
        #2 chk_out("s1_out", 2'b11, 1'b1, 8'h95);
        step();
        #2 chk_out("s1_idle", 2'b11, 1'b0, 8'h00);

        // Back-to-back on stream1.
        set_in(2'b10, 7'h01, 7'h00);
        step();
        set_in(2'b10, 7'h02, 7'h00);
        #2 chk_out("b2b_first", 2'b11, 1'b1, 8'h81);
        step();
        set_in(2'b00, 7'h00, 7'h00);
        #2 chk_out("b2b_second", 2'b11, 1'b1, 8'h82);
        step();
        #2 chk_out("b2b_idle", 2'b11, 1'b0, 8'h00);

        // Both streams held continuously.
        set_in(2'b11, 7'h55, 7'h2A);
        step();
`ifdef FLUX_ARB_FIXED_PRIO_EN
        #2 chk_out("both_a", 2'b10, 1'b1, 8'hD5);
        step();
        #2 chk_out("both_b", 2'b10, 1'b1, 8'hD5);
        step();
        #2 chk_out("both_c", 2'b10, 1'b1, 8'hD5);
`else
        #2 chk_out("rr_a", 2'b01, 1'b1, 8'h2A);
        step();
        #2 chk_out("rr_b", 2'b10, 1'b1, 8'hD5);
        step();
        #2 chk_out("rr_c", 2'b01, 1'b1, 8'h2A);
`endif
        step();
        set_in(2'b00, 7'h00, 7'h00);
        #2 chk_out("drain_1", 2'b10, 1'b1, 8'hD5);
        step();
        #2 chk_out("drain_0", 2'b11, 1'b1, 8'h2A);
        step();
        #2 chk_out("drain_idle", 2'b11, 1'b0, 8'h00);

        // Full bypass: stream0's queue full, stream1 proceeds.
        fifo_full = 2'b01;
        set_in(2'b11, 7'h22, 7'h11);
        step();
        set_in(2'b00, 7'h00, 7'h00);
        #2 chk_out("full_s1", 2'b10, 1'b1, 8'hA2);
        step();
        #2 chk_out("full_stall", 2'b10, 1'b0, 8'h00);
        step();
        #2 chk_out("full_still", 2'b10, 1'b0, 8'h00);
        fifo_full = 2'b00;
        #1 chk_out("full_release", 2'b11, 1'b1, 8'h11);
        step();
        #2 chk_out("full_idle", 2'b11, 1'b0, 8'h00);

        // Same-cycle refill on stream0.
        set_in(2'b01, 7'h00, 7'h44);
        step();
        set_in(2'b01, 7'h00, 7'h33);
        #2 chk_out("refill_old", 2'b11, 1'b1, 8'h44);
        step();
        set_in(2'b00, 7'h00, 7'h00);
        #2 chk_out("refill_new", 2'b11, 1'b1, 8'h33);
        step();
        #2 chk_out("refill_idle", 2'b11, 1'b0, 8'h00);

        // Asynchronous reset mid-cycle with both streams held.
        set_in(2'b11, 7'h06, 7'h05);
        step();
        set_in(2'b00, 7'h00, 7'h00);
        #2 chk_out("pre_rst", 2'b10, 1'b1, 8'h86);
        #2 rst = 1'b1;
        #1 chk_out("async_rst", 2'b11, 1'b0, 8'h00);
        step();
        rst = 1'b0;
        #2 chk_out("post_rst", 2'b11, 1'b0, 8'h00);
        step();
        #2 chk_out("post_rst_idle", 2'b11, 1'b0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
